// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-lite encodings, default-slave states and helpers
// Purpose : common types and constants for the AHB-lite slave response mux.
// Contents: HTRANS encodings, HRESP values, default-slave FSM state enum,
//           NUM_PORTS, and a lowest-set-bit priority helper.
package ahb_pkg;

    localparam int NUM_PORTS = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    // Isolate the lowest set bit: two's complement AND keeps only that bit,
    // which gives "lowest port index wins" priority.
    function automatic logic [NUM_PORTS-1:0] lowest_set(input logic [NUM_PORTS-1:0] v);
        return v & (~v + NUM_PORTS'(1));
    endfunction

endpackage

// File: rtl/ahblite_slave_mux_if.sv
// rtl/ahblite_slave_mux_if.sv - AHB-lite bus bundle between decoder, slaves, mux and master
// Purpose : groups the address-phase controls, the four slave response sets and
//           the muxed response back to the master.
// Modports: slave  - view used by the response mux (responses are outputs)
//           master - view used by the master/decoder/slave models
interface ahblite_slave_mux_if;

    logic [1:0]  HTRANS;

    logic        P0_HSEL;
    logic        P1_HSEL;
    logic        P2_HSEL;
    logic        P3_HSEL;

    logic [31:0] P0_HRDATA;
    logic [31:0] P1_HRDATA;
    logic [31:0] P2_HRDATA;
    logic [31:0] P3_HRDATA;

    logic        P0_HREADYOUT;
    logic        P1_HREADYOUT;
    logic        P2_HREADYOUT;
    logic        P3_HREADYOUT;

    logic        P0_HRESP;
    logic        P1_HRESP;
    logic        P2_HRESP;
    logic        P3_HRESP;

    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport slave (
        input  HTRANS,
        input  P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL,
        input  P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA,
        input  P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT,
        input  P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP,
        output HREADY, HRDATA, HRESP
    );

    modport master (
        output HTRANS,
        output P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL,
        output P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA,
        output P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT,
        output P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP,
        input  HREADY, HRDATA, HRESP
    );

endinterface

// File: rtl/ahblite_default_slave.sv
// rtl/ahblite_default_slave.sv - default slave producing the two-cycle AHB ERROR response
// Purpose : IDLE/ERR1/ERR2 FSM answering unmapped active transfers; with
//           AHB_MUX_TIMEOUT_EN defined it also aborts a stalled mapped slave.
// Ports   : clk_i, rst_ni      clock, asynchronous active-low reset
//           hready_i           muxed HREADY (address phase sampled when 1)
//           unmapped_req_i     address phase is active with no enabled select
//           mapped_stall_i     (AHB_MUX_TIMEOUT_EN only) mapped data phase waiting
//           ds_active_o        FSM owns the data-phase response
//           ds_hreadyout_o     default-slave ready
//           ds_hresp_o         default-slave response
// Macro   : AHB_MUX_TIMEOUT_EN enables the stall watchdog.
module ahblite_default_slave
    import ahb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic hready_i,
    input  logic unmapped_req_i,
`ifdef AHB_MUX_TIMEOUT_EN
    input  logic mapped_stall_i,
`endif
    output logic ds_active_o,
    output logic ds_hreadyout_o,
    output logic ds_hresp_o
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..65535");
    end

    ds_state_e state_q, state_d;
    logic      timeout_hit;

`ifdef AHB_MUX_TIMEOUT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Count only while a mapped slave holds the bus; any ready cycle clears it.
    always_comb begin
        stall_cnt_d = '0;
        if (mapped_stall_i && state_q == DS_IDLE) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Fire one cycle early so ERR1 is on the bus in the cycle the count reaches
    // TIMEOUT_CYCLES-1.
    assign timeout_hit = mapped_stall_i && (state_q == DS_IDLE) &&
                         (stall_cnt_q == 16'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ds_hreadyout_o = 1'b1;
        ds_hresp_o     = HRESP_OKAY;
        unique case (state_q)
            DS_IDLE: begin
                if ((hready_i && unmapped_req_i) || timeout_hit) begin
                    state_d = DS_ERR1;
                end
            end
            DS_ERR1: begin
                ds_hreadyout_o = 1'b0;
                ds_hresp_o     = HRESP_ERROR;
                state_d        = DS_ERR2;
            end
            DS_ERR2: begin
                // HREADY is high here, so a new address phase is being sampled.
                ds_hresp_o = HRESP_ERROR;
                state_d    = (hready_i && unmapped_req_i) ? DS_ERR1 : DS_IDLE;
            end
            default: begin
                state_d = DS_IDLE;
            end
        endcase
    end

    assign ds_active_o = (state_q != DS_IDLE);

endmodule

// File: rtl/ahblite_slave_mux.sv
// rtl/ahblite_slave_mux.sv - AHB-lite data-phase response multiplexer with default slave
// Purpose : registers the decoded port select into the data phase and steers
//           the selected slave's HRDATA/HREADYOUT/HRESP back to the master;
//           unmapped active transfers get a two-cycle ERROR.
// Ports   : HCLK     system clock
//           HRESETn  asynchronous active-low reset
//           bus      ahblite_slave_mux_if.slave (HTRANS, Pn_HSEL, Pn_HRDATA,
//                    Pn_HREADYOUT, Pn_HRESP in; HREADY, HRDATA, HRESP out)
// Macro   : AHB_MUX_TIMEOUT_EN enables the stalled-slave watchdog.
module ahblite_slave_mux
    import ahb_pkg::*;
#(
    parameter bit PORT0_EN       = 1'b1,
    parameter bit PORT1_EN       = 1'b1,
    parameter bit PORT2_EN       = 1'b1,
    parameter bit PORT3_EN       = 1'b1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    ahblite_slave_mux_if.slave  bus
);

    logic [NUM_PORTS-1:0] hsel_en;
    logic [NUM_PORTS-1:0] sel_dp_q, sel_dp_d;
    logic                 def_req_q, def_req_d;
    logic                 unmapped_req;

    logic [31:0]          slv_rdata;
    logic                 slv_ready;
    logic                 slv_resp;

    logic                 ds_active;
    logic                 ds_hreadyout;
    logic                 ds_hresp;

    logic                 mux_hready;
    logic [31:0]          mux_hrdata;
    logic                 mux_hresp;

    assign hsel_en = {bus.P3_HSEL & PORT3_EN,
                      bus.P2_HSEL & PORT2_EN,
                      bus.P1_HSEL & PORT1_EN,
                      bus.P0_HSEL & PORT0_EN};

    // Only NONSEQ/SEQ need the error; IDLE/BUSY to a hole completes as OKAY.
    assign unmapped_req = (hsel_en == '0) && bus.HTRANS[1];

    always_comb begin
        sel_dp_d  = sel_dp_q;
        def_req_d = def_req_q;
        if (mux_hready) begin
            sel_dp_d  = lowest_set(hsel_en);
            def_req_d = unmapped_req;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_dp_q  <= '0;
            def_req_q <= 1'b0;
        end else begin
            sel_dp_q  <= sel_dp_d;
            def_req_q <= def_req_d;
        end
    end

    // Unselected ports never reach the outputs, so X on them is harmless.
    always_comb begin
        slv_rdata = '0;
        slv_ready = 1'b1;
        slv_resp  = HRESP_OKAY;
        if (sel_dp_q[0]) begin
            slv_rdata = bus.P0_HRDATA;
            slv_ready = bus.P0_HREADYOUT;
            slv_resp  = bus.P0_HRESP;
        end else if (sel_dp_q[1]) begin
            slv_rdata = bus.P1_HRDATA;
            slv_ready = bus.P1_HREADYOUT;
            slv_resp  = bus.P1_HRESP;
        end else if (sel_dp_q[2]) begin
            slv_rdata = bus.P2_HRDATA;
            slv_ready = bus.P2_HREADYOUT;
            slv_resp  = bus.P2_HRESP;
        end else if (sel_dp_q[3]) begin
            slv_rdata = bus.P3_HRDATA;
            slv_ready = bus.P3_HREADYOUT;
            slv_resp  = bus.P3_HRESP;
        end
    end

    ahblite_default_slave #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_default_slave (
        .clk_i          (HCLK),
        .rst_ni         (HRESETn),
        .hready_i       (mux_hready),
        .unmapped_req_i (unmapped_req),
`ifdef AHB_MUX_TIMEOUT_EN
        .mapped_stall_i ((|sel_dp_q) && !slv_ready && !def_req_q),
`endif
        .ds_active_o    (ds_active),
        .ds_hreadyout_o (ds_hreadyout),
        .ds_hresp_o     (ds_hresp)
    );

    // The default slave wins whenever it is busy; after a watchdog abort this
    // keeps the abandoned slave off the bus until the next address phase.
    always_comb begin
        mux_hrdata = slv_rdata;
        mux_hready = slv_ready;
        mux_hresp  = slv_resp;
        if (def_req_q || ds_active) begin
            mux_hrdata = '0;
            mux_hready = ds_hreadyout;
            mux_hresp  = ds_hresp;
        end
    end

    assign bus.HRDATA = mux_hrdata;
    assign bus.HREADY = mux_hready;
    assign bus.HRESP  = mux_hresp;

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// tb/tb_ahblite_slave_mux.sv - self-checking bench for ahblite_slave_mux
module tb_ahblite_slave_mux;
    import ahb_pkg::*;

    typedef struct {
        logic [1:0]  htrans;
        logic [3:0]  hsel;
        logic [3:0]  rdy;
        logic [3:0]  resp;
        logic        exp_rdy;
        logic        exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'hDEAD_BEEF;
    localparam logic [31:0] D2 = 32'h2222_0000;
    localparam logic [31:0] D3 = 32'h3333_0000;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    always #5 HCLK = ~HCLK;

    ahblite_slave_mux_if bus();

    ahblite_slave_mux #(
        .PORT0_EN       (1'b1),
        .PORT1_EN       (1'b1),
        .PORT2_EN       (1'b0),
        .PORT3_EN       (1'b1),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    function automatic vec_t mk(input logic [1:0] t, input logic [3:0] s, input logic [3:0] r,
                                input logic [3:0] e, input logic xr, input logic xe,
                                input logic [31:0] xd);
        vec_t v;
        v.htrans = t; v.hsel = s; v.rdy = r; v.resp = e;
        v.exp_rdy = xr; v.exp_resp = xe; v.exp_data = xd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.HTRANS       = v.htrans;
        bus.P0_HSEL      = v.hsel[0];
        bus.P1_HSEL      = v.hsel[1];
        bus.P2_HSEL      = v.hsel[2];
        bus.P3_HSEL      = v.hsel[3];
        bus.P0_HREADYOUT = v.rdy[0];
        bus.P1_HREADYOUT = v.rdy[1];
        bus.P2_HREADYOUT = v.rdy[2];
        bus.P3_HREADYOUT = v.rdy[3];
        bus.P0_HRESP     = v.resp[0];
        bus.P1_HRESP     = v.resp[1];
        bus.P2_HRESP     = v.resp[2];
        bus.P3_HRESP     = v.resp[3];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic xr, input logic xe, input logic [31:0] xd);
        check({tag, " HREADY"}, {31'd0, bus.HREADY}, {31'd0, xr});
        check({tag, " HRESP"},  {31'd0, bus.HRESP},  {31'd0, xe});
        check({tag, " HRDATA"}, bus.HRDATA, xd);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        @(posedge HCLK);
        #1;
        drive(v);
        #3;
        check_out(tag, v.exp_rdy, v.exp_resp, v.exp_data);
    endtask

    initial begin
        bus.P0_HRDATA = D0;
        bus.P1_HRDATA = D1;
        bus.P2_HRDATA = D2;
        bus.P3_HRDATA = D3;
        drive(mk(HTRANS_IDLE, 4'b0000, 4'hF, 4'h0, 1'b1, 1'b0, 32'h0));

        // Reset values appear without any clock edge.
        #1 HRESETn = 1'b0;
        #1 check_out("reset", 1'b1, 1'b0, 32'h0);
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        // Each row is one bus cycle; rows chain so the data phase of one row
        // follows the address phase of the previous.
        vecs.push_back(mk(HTRANS_IDLE,   4'b0000, 4'hF, 4'h0, 1, 0, 32'h0)); // 0 idle
        vecs.push_back(mk(HTRANS_NONSEQ, 4'b0010, 4'hF, 4'h0, 1, 0, 32'h0)); // 1 P1 addr
        vecs.push_back(mk(HTRANS_NONSEQ, 4'b0001, 4'hD, 4'h0, 0, 0, D1));    // 2 P1 wait, P0 addr held
        vecs.push_back(mk(HTRANS_NONSEQ, 4'b0001, 4'hD, 4'h0, 0, 0, D1));    // 3 P1 wait
        vecs.push_back(mk(HTRANS_IDLE,   4'b0000, 4'hF, 4'h0, 1, 0, D1));    // 4 P1 done
        vecs.push_back(mk(HTRANS_NONSEQ, 4'b0000, 4'hF, 4'h0, 1, 0, 32'h0)); // 5 unmapped addr
        vecs.push_back(mk(HTRANS_IDLE,   4'b0000, 4'hF, 4'h0, 0, 1, 32'h0)); // 6 ERR1
        vecs.push_back(mk(HTRANS_IDLE,   4'b0000, 4'hF, 4'h0, 1, 1, 32'h0)); // 7 ERR2
        vecs.push_back(mk(HTRANS_BUSY,   4'b0000, 4'hF, 4'h0, 1, 0, 32'h0)); // 8 idle OKAY
        vecs.push_back(mk(HTRANS_NONSEQ, 4'b0000, 4'hF, 4'h0, 1, 0, 32'h0)); // 9 BUSY OKAY
        vecs.push_back(mk(HTRANS_NONSEQ, 4'b0000, 4'hF, 4'h0, 0, 1, 32'h0)); // 10 ERR1
        vecs.push_back(mk(HTRANS_NONSEQ, 4'b0000, 4'hF, 4'h0, 1, 1, 32'h0)); // 11 ERR2 + new unmapped
        vecs.push_back(mk(HTRANS_IDLE,   4'b0000, 4'hF, 4'h0, 0, 1, 32'h0)); // 12 ERR1 no gap
        vecs.push_back(mk(HTRANS_IDLE,   4'b0000, 4'hF, 4'h0, 1, 1, 32'h0)); // 13 ERR2
        vecs.push_back(mk(HTRANS_NONSEQ, 4'b0100, 4'hF, 4'h0, 1, 0, 32'h0)); // 14 disabled P2
        vecs.push_back(mk(HTRANS_IDLE,   4'b0000, 4'hF, 4'h0, 0, 1, 32'h0)); // 15 ERR1
        vecs.push_back(mk(HTRANS_IDLE,   4'b0000, 4'hF, 4'h0, 1, 1, 32'h0)); // 16 ERR2
        vecs.push_back(mk(HTRANS_NONSEQ, 4'b1001, 4'hF, 4'h0, 1, 0, 32'h0)); // 17 P0+P3 addr
        vecs.push_back(mk(HTRANS_IDLE,   4'b0000, 4'h7, 4'h0, 1, 0, D0));    // 18 P0 wins, P3 ignored
        vecs.push_back(mk(HTRANS_NONSEQ, 4'b0001, 4'hF, 4'h0, 1, 0, 32'h0)); // 19 P0 addr
        vecs.push_back(mk(HTRANS_IDLE,   4'b0000, 4'hE, 4'h1, 0, 1, D0));    // 20 P0 error cycle 1
        vecs.push_back(mk(HTRANS_IDLE,   4'b0000, 4'hF, 4'h1, 1, 1, D0));    // 21 P0 error cycle 2
        vecs.push_back(mk(HTRANS_IDLE,   4'b0000, 4'hF, 4'h0, 1, 0, 32'h0)); // 22 idle
`ifdef AHB_MUX_TIMEOUT_EN
        vecs.push_back(mk(HTRANS_NONSEQ, 4'b1000, 4'hF, 4'h0, 1, 0, 32'h0)); // P3 addr
        vecs.push_back(mk(HTRANS_IDLE,   4'b0000, 4'h7, 4'h0, 0, 0, D3));    // stall 1
        vecs.push_back(mk(HTRANS_IDLE,   4'b0000, 4'h7, 4'h0, 0, 0, D3));    // stall 2
        vecs.push_back(mk(HTRANS_IDLE,   4'b0000, 4'h7, 4'h0, 0, 0, D3));    // stall 3
        vecs.push_back(mk(HTRANS_IDLE,   4'b0000, 4'h7, 4'h0, 0, 1, 32'h0)); // stall 4 -> ERR1
        vecs.push_back(mk(HTRANS_IDLE,   4'b0000, 4'h7, 4'h0, 1, 1, 32'h0)); // ERR2
        vecs.push_back(mk(HTRANS_IDLE,   4'b0000, 4'h7, 4'h0, 1, 0, 32'h0)); // P3 ignored
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec($sformatf("row%0d", i), vecs[i]);
        end

        // Reset asserted in the middle of ERR1.
        run_vec("pre_err_addr", mk(HTRANS_NONSEQ, 4'b0000, 4'hF, 4'h0, 1, 0, 32'h0));
        run_vec("pre_err_err1", mk(HTRANS_IDLE,   4'b0000, 4'hF, 4'h0, 0, 1, 32'h0));
        HRESETn = 1'b0;
        #1 check_out("mid_err1_reset", 1'b1, 1'b0, 32'h0);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        run_vec("post_rst_addr", mk(HTRANS_NONSEQ, 4'b1000, 4'hF, 4'h0, 1, 0, 32'h0));
        run_vec("post_rst_data", mk(HTRANS_IDLE,   4'b0000, 4'hF, 4'h0, 1, 0, D3));
        run_vec("post_rst_idle", mk(HTRANS_IDLE,   4'b0000, 4'hF, 4'h0, 1, 0, 32'h0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
